// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_pattern_pkg;

  localparam int unsigned PWM_WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_FILL   = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_tick_div.sv
// Step-rate divider: counts 0..DIV_MAX and fires tick in the cycle it wraps.
// The counter and its wrap both freeze while PAUSE_IN is high.
module led_tick_div #(
  parameter int unsigned DIV_WIDTH = 24,
  parameter int unsigned DIV_MAX   = 16777215
) (
  input  logic CLK_IN,
  input  logic RST_IN,
  input  logic PAUSE_IN,
  output logic tick
);

  localparam logic [DIV_WIDTH-1:0] DIV_TERM = DIV_WIDTH'(DIV_MAX);

  logic [DIV_WIDTH-1:0] div_q;

  // Combinational so the pattern updates on the same edge the divider wraps.
  assign tick = !PAUSE_IN && (div_q == DIV_TERM);

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      div_q <= '0;
    end else if (!PAUSE_IN) begin
      div_q <= tick ? '0 : div_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern sequencer: fill / chase / bounce / blink advanced once per divider tick.
// Define LED_PATTERN_PWM_EN to add a registered PWM brightness stage on LED_OUT.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned NUM_LEDS  = 5,
  parameter int unsigned DIV_WIDTH = 24,
  parameter int unsigned DIV_MAX   = 16777215
) (
  input  logic                 CLK_IN,
  input  logic                 RST_IN,
  input  logic [1:0]           MODE_IN,
  input  logic                 PAUSE_IN,
  input  logic [PWM_WIDTH-1:0] BRIGHT_IN,
  output logic [NUM_LEDS-1:0]  LED_OUT,
  output logic                 STEP_OUT
);

  logic                tick;
  mode_e               mode_q, mode_d, mode_in_c;
  dir_e                dir_q, dir_d;
  logic [NUM_LEDS-1:0] pat_q, pat_d;
  logic                step_q;

  led_tick_div #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_MAX   (DIV_MAX)
  ) u_div (
    .CLK_IN   (CLK_IN),
    .RST_IN   (RST_IN),
    .PAUSE_IN (PAUSE_IN),
    .tick     (tick)
  );

  assign mode_in_c = mode_e'(MODE_IN);

  // A tick either switches mode (loading its start pattern) or advances the current one.
  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    pat_d  = pat_q;
    if (tick) begin
      if (mode_in_c != mode_q) begin
        mode_d = mode_in_c;
        dir_d  = DIR_UP;
        case (mode_in_c)
          MODE_CHASE, MODE_BOUNCE: pat_d = NUM_LEDS'(1);
          default:                 pat_d = '0;
        endcase
      end else begin
        case (mode_q)
          MODE_FILL:  pat_d = (&pat_q) ? '0 : {pat_q[NUM_LEDS-2:0], 1'b1};
          MODE_CHASE: pat_d = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
          MODE_BOUNCE: begin
            // Turn around at either end without repeating the end position.
            if (dir_q == DIR_UP) begin
              if (pat_q[NUM_LEDS-1]) begin
                dir_d = DIR_DOWN;
                pat_d = pat_q >> 1;
              end else begin
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                dir_d = DIR_UP;
                pat_d = pat_q << 1;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
          default:    pat_d = ~pat_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      mode_q <= MODE_FILL;
      dir_q  <= DIR_UP;
      pat_q  <= '0;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pat_q  <= pat_d;
      step_q <= tick;
    end
  end

`ifdef LED_PATTERN_PWM_EN
  logic [PWM_WIDTH-1:0] pwm_cnt_q;
  logic [NUM_LEDS-1:0]  led_q;
  logic                 step_dly_q;
  logic                 pwm_on_c;

  // Full scale bypasses the compare so BRIGHT_IN = 15 is continuously on.
  assign pwm_on_c = (BRIGHT_IN == '1) || (pwm_cnt_q < BRIGHT_IN);

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      pwm_cnt_q  <= '0;
      led_q      <= '0;
      step_dly_q <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_q + PWM_WIDTH'(1);
      led_q      <= pat_q & {NUM_LEDS{pwm_on_c}};
      step_dly_q <= step_q;
    end
  end

  assign LED_OUT  = led_q;
  assign STEP_OUT = step_dly_q;
`else
  logic unused_bright;

  assign unused_bright = ^BRIGHT_IN;
  assign LED_OUT       = pat_q;
  assign STEP_OUT      = step_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (NUM_LEDS=5, 4-cycle step).
module tb_led_pattern_gen;

  localparam int NL = 5;
  localparam int DM = 3;
`ifdef LED_PATTERN_PWM_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          pause = 1'b0;
  logic [3:0]    bright = 4'd15;
  logic [NL-1:0] led_out;
  logic          step_out;

  int passes = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_pattern_gen #(
    .NUM_LEDS  (NL),
    .DIV_WIDTH (2),
    .DIV_MAX   (DM)
  ) dut (
    .CLK_IN    (clk),
    .RST_IN    (rst),
    .MODE_IN   (mode),
    .PAUSE_IN  (pause),
    .BRIGHT_IN (bright),
    .LED_OUT   (led_out),
    .STEP_OUT  (step_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Pattern as a closed-form function of mode and number of advances since the mode loaded.
  function automatic logic [NL-1:0] pat_of(input int m, input int idx);
    int k;
    case (m)
      0: begin k = idx % (NL + 1); return NL'((1 << k) - 1); end
      1: return NL'(1 << (idx % NL));
      2: begin
        k = idx % (2 * NL - 2);
        if (k >= NL) k = 2 * NL - 2 - k;
        return NL'(1 << k);
      end
      default: return (idx % 2 == 1) ? {NL{1'b1}} : {NL{1'b0}};
    endcase
  endfunction

  function automatic bit bright_on(input int c, input int b);
    return (b == 15) || (c < b);
  endfunction

  int            m_mode, m_idx, m_div, m_pwm;
  logic          m_step, m_step_d;
  logic [NL-1:0] m_led_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_idx <= 0; m_div <= 0; m_pwm <= 0;
      m_step <= 1'b0; m_step_d <= 1'b0; m_led_d <= '0;
    end else begin
      m_pwm    <= (m_pwm + 1) % 16;
      m_led_d  <= pat_of(m_mode, m_idx) & {NL{bright_on(m_pwm, int'(bright))}};
      m_step_d <= m_step;
      m_step   <= 1'b0;
      if (!pause) begin
        if (m_div == DM) begin
          m_div  <= 0;
          m_step <= 1'b1;
          if (int'(mode) != m_mode) begin
            m_mode <= int'(mode);
            m_idx  <= 0;
          end else begin
            m_idx <= m_idx + 1;
          end
        end else begin
          m_div <= m_div + 1;
        end
      end
    end
  end

  logic [NL-1:0] exp_led;
  logic          exp_step;
  always_comb begin
`ifdef LED_PATTERN_PWM_EN
    exp_led  = m_led_d;
    exp_step = m_step_d;
`else
    exp_led  = pat_of(m_mode, m_idx);
    exp_step = m_step;
`endif
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("led_cycle", 32'(led_out), 32'(exp_led));
      check("step_cycle", 32'(step_out), 32'(exp_step));
    end
  end

  int last_step = 0;
  int step_gap = 0;

  task automatic wait_step(input string name, input logic [NL-1:0] lit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (step_out !== 1'b1 && n < 40);
    check({name, "_timeout"}, 32'(n < 40), 32'd1);
    check(name, 32'(led_out), 32'(lit));
    step_gap  = cyc - last_step;
    last_step = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [NL-1:0] held;
  int            cnt;
  int            rel_cyc;

  initial begin
    #1 rst = 1'b1;
    #2;
    check("reset_led", 32'(led_out), 32'd0);
    check("reset_step", 32'(step_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // FILL from reset
    wait_step("fill1", 5'b00001);
    wait_step("fill2", 5'b00011);
    check("fill_period", 32'(step_gap), 32'd4);
    wait_step("fill3", 5'b00111);
    wait_step("fill4", 5'b01111);
    wait_step("fill5", 5'b11111);
    check("fill_period2", 32'(step_gap), 32'd4);
    wait_step("fill6", 5'b00000);

    // CHASE, then switch to FILL mid-step
    mode = 2'd1;
    wait_step("chase_load", 5'b00001);
    wait_step("chase1", 5'b00010);
    wait_step("chase2", 5'b00100);
    wait_step("chase3", 5'b01000);
    wait_step("chase4", 5'b10000);
    @(negedge clk);
    mode = 2'd0;
    wait_step("fill_reload", 5'b00000);
    wait_step("fill_after", 5'b00001);

    // Pause for 10 cycles across a divider wrap
    repeat (2) @(negedge clk);
    held  = led_out;
    pause = 1'b1;
    cnt   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (step_out) cnt++;
    end
    pause = 1'b0;
    check("pause_no_step", 32'(cnt), 32'd0);
    check("pause_frozen", 32'(led_out), 32'(held));
    wait_step("after_pause", 5'b00011);
    check("pause_gap", 32'(step_gap), 32'd14);

    // BOUNCE from reset
    do_reset();
    mode = 2'd2;
    wait_step("bounce_load", 5'b00001);
    wait_step("bounce1", 5'b00010);
    wait_step("bounce2", 5'b00100);
    wait_step("bounce3", 5'b01000);
    wait_step("bounce4", 5'b10000);
    wait_step("bounce5", 5'b01000);
    wait_step("bounce6", 5'b00100);
    wait_step("bounce7", 5'b00010);
    wait_step("bounce8", 5'b00001);
    wait_step("bounce9", 5'b00010);

    // BLINK, then asynchronous reset between edges
    mode = 2'd3;
    wait_step("blink_load", 5'b00000);
    wait_step("blink1", 5'b11111);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led_out), 32'd0);
    check("async_rst_step", 32'(step_out), 32'd0);
    mode = 2'd0;
    @(negedge clk);
    #2 rst = 1'b0;
    rel_cyc = cyc;
    wait_step("fill_restart", 5'b00001);
    check("first_tick_latency", 32'(last_step - rel_cyc), 32'(4 + LAT));

`ifdef LED_PATTERN_PWM_EN
    mode = 2'd3;
    wait_step("pwm_blink_load", 5'b00000);
    wait_step("pwm_blink_on", 5'b11111);
    pause = 1'b1;
    for (int b = 0; b < 3; b++) begin
      bright = (b == 0) ? 4'd4 : ((b == 1) ? 4'd0 : 4'd15);
      repeat (2) @(negedge clk);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (led_out == 5'b11111) cnt++;
      end
      check("pwm_duty", 32'(cnt), (b == 0) ? 32'd4 : ((b == 1) ? 32'd0 : 32'd16));
    end
    pause  = 1'b0;
    bright = 4'd15;
`endif

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule
